// File: rtl/select_encode_regfile.sv
// Register-file end of the datapath bus: instruction register, R0-R15, the
// IR-field select/decode that steers writes and read strobes, and constant C.
module select_encode_regfile (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] busMuxOut,
  input  logic        IRin,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  output logic [31:0] irQ,
  output logic [31:0] r0Q,
  output logic [31:0] r1Q,
  output logic [31:0] r2Q,
  output logic [31:0] r3Q,
  output logic [31:0] r4Q,
  output logic [31:0] r5Q,
  output logic [31:0] r6Q,
  output logic [31:0] r7Q,
  output logic [31:0] r8Q,
  output logic [31:0] r9Q,
  output logic [31:0] r10Q,
  output logic [31:0] r11Q,
  output logic [31:0] r12Q,
  output logic [31:0] r13Q,
  output logic [31:0] r14Q,
  output logic [31:0] r15Q,
  output logic [15:0] rOut,
  output logic [31:0] C_sign_extended,
  output logic        selErr
);

  logic [31:0] ir_q, ir_d;
  logic [31:0] regs_q [16];
  logic [31:0] regs_d [16];
  logic        selErr_q, selErr_d;
  logic [3:0]  sel;
  logic        selActive;
  logic        multiSel;
  logic [15:0] decode;

  // Field select always comes from the registered IR, so a same-cycle IR load
  // only affects selection from the following cycle.
  always_comb begin
    sel = ir_q[18:15];
    if (Gra) begin
      sel = ir_q[26:23];
    end else if (Grb) begin
      sel = ir_q[22:19];
    end else begin
      sel = ir_q[18:15];
    end
  end

  assign selActive = Gra | Grb | Grc;
  assign multiSel  = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);

  always_comb begin
    decode = '0;
    if (selActive) begin
      decode[sel] = 1'b1;
    end
  end

  always_comb begin
    for (int n = 0; n < 16; n++) begin
      regs_d[n] = regs_q[n];
    end
    if (Rin && selActive) begin
      regs_d[sel] = busMuxOut;
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (IRin) begin
      ir_d = busMuxOut;
    end
  end

  // Ambiguous selects are only an error when a strobe would actually use them.
  always_comb begin
    selErr_d = selErr_q;
    if (multiSel && (Rin || Rout || BAout)) begin
      selErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ir_q     <= '0;
      selErr_q <= 1'b0;
      for (int n = 0; n < 16; n++) begin
        regs_q[n] <= '0;
      end
    end else begin
      ir_q     <= ir_d;
      selErr_q <= selErr_d;
      for (int n = 0; n < 16; n++) begin
        regs_q[n] <= regs_d[n];
      end
    end
  end

  assign rOut            = decode & {16{Rout | BAout}};
  assign irQ             = ir_q;
  assign selErr          = selErr_q;
  assign C_sign_extended = {{13{ir_q[18]}}, ir_q[18:0]};

  // BAout gives base-address semantics: R0 reads as zero on the bus.
  assign r0Q  = BAout ? 32'd0 : regs_q[0];
  assign r1Q  = regs_q[1];
  assign r2Q  = regs_q[2];
  assign r3Q  = regs_q[3];
  assign r4Q  = regs_q[4];
  assign r5Q  = regs_q[5];
  assign r6Q  = regs_q[6];
  assign r7Q  = regs_q[7];
  assign r8Q  = regs_q[8];
  assign r9Q  = regs_q[9];
  assign r10Q = regs_q[10];
  assign r11Q = regs_q[11];
  assign r12Q = regs_q[12];
  assign r13Q = regs_q[13];
  assign r14Q = regs_q[14];
  assign r15Q = regs_q[15];

endmodule

// File: tb/tb_select_encode_regfile.sv
// Scoreboard bench for select_encode_regfile: expectations are queued as
// stimulus is driven and popped when the corresponding output is sampled.
module tb_select_encode_regfile;

  logic        clk;
  logic        clr_n;
  logic [31:0] busMuxOut;
  logic        IRin, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [31:0] irQ, C_sign_extended;
  logic [31:0] r0Q, r1Q, r2Q, r3Q, r4Q, r5Q, r6Q, r7Q;
  logic [31:0] r8Q, r9Q, r10Q, r11Q, r12Q, r13Q, r14Q, r15Q;
  logic [15:0] rOut;
  logic        selErr;
  logic [31:0] rq [16];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  select_encode_regfile dut (
    .clk(clk), .clr_n(clr_n), .busMuxOut(busMuxOut), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .irQ(irQ),
    .r0Q(r0Q), .r1Q(r1Q), .r2Q(r2Q), .r3Q(r3Q), .r4Q(r4Q), .r5Q(r5Q),
    .r6Q(r6Q), .r7Q(r7Q), .r8Q(r8Q), .r9Q(r9Q), .r10Q(r10Q), .r11Q(r11Q),
    .r12Q(r12Q), .r13Q(r13Q), .r14Q(r14Q), .r15Q(r15Q),
    .rOut(rOut), .C_sign_extended(C_sign_extended), .selErr(selErr)
  );

  assign rq[0] = r0Q;   assign rq[1] = r1Q;   assign rq[2] = r2Q;   assign rq[3] = r3Q;
  assign rq[4] = r4Q;   assign rq[5] = r5Q;   assign rq[6] = r6Q;   assign rq[7] = r7Q;
  assign rq[8] = r8Q;   assign rq[9] = r9Q;   assign rq[10] = r10Q; assign rq[11] = r11Q;
  assign rq[12] = r12Q; assign rq[13] = r13Q; assign rq[14] = r14Q; assign rq[15] = r15Q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    IRin = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loadIr(input logic [31:0] v);
    @(negedge clk);
    idle();
    IRin = 1; busMuxOut = v;
    tick();
  endtask

  task automatic test_reset();
    // Power-on reset values, and rOut following inputs with sel = 0
    clr_n = 0; idle(); busMuxOut = 0;
    #1;
    sb.push_back('{"rst_irQ", 32'h0});
    sb.push_back('{"rst_selErr", 32'h0});
    sb.push_back('{"rst_C", 32'h0});
    e = sb.pop_front(); checks++;
    if (irQ !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, irQ, e.val); end
    e = sb.pop_front(); checks++;
    if ({31'd0, selErr} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, selErr, e.val); end
    e = sb.pop_front(); checks++;
    if (C_sign_extended !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, C_sign_extended, e.val); end
    Gra = 1; Rout = 1;
    sb.push_back('{"rst_rOut", 32'h0001});
    #1;
    e = sb.pop_front(); checks++;
    if ({16'd0, rOut} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rOut, e.val); end
    idle();
    #1 clr_n = 1;

    // Write R5 and set selErr, then an asynchronous reset between edges
    loadIr(32'h0280_0000);
    @(negedge clk); idle(); Gra = 1; Rin = 1; busMuxOut = 32'h1234_5678;
    sb.push_back('{"pre_r5", 32'h1234_5678});
    tick();
    e = sb.pop_front(); checks++;
    if (r5Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r5Q, e.val); end
    @(negedge clk); idle(); Gra = 1; Grb = 1; Rout = 1;
    sb.push_back('{"pre_selErr", 32'h1});
    tick();
    e = sb.pop_front(); checks++;
    if ({31'd0, selErr} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, selErr, e.val); end
    @(negedge clk); idle();
    clr_n = 0;
    sb.push_back('{"async_r5", 32'h0});
    sb.push_back('{"async_irQ", 32'h0});
    sb.push_back('{"async_selErr", 32'h0});
    #2;
    e = sb.pop_front(); checks++;
    if (r5Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r5Q, e.val); end
    e = sb.pop_front(); checks++;
    if (irQ !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, irQ, e.val); end
    e = sb.pop_front(); checks++;
    if ({31'd0, selErr} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, selErr, e.val); end
    clr_n = 1;
  endtask

  task automatic test_ir_write_ra();
    // First edge after reset release loads IR normally
    @(negedge clk); idle(); IRin = 1; busMuxOut = 32'h0180_0000;
    sb.push_back('{"ir_load", 32'h0180_0000});
    tick();
    e = sb.pop_front(); checks++;
    if (irQ !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, irQ, e.val); end
    @(negedge clk); idle(); Gra = 1; Rin = 1; busMuxOut = 32'hDEAD_BEEF;
    for (int n = 0; n < 16; n++) sb.push_back('{$sformatf("ra_r%0d", n), (n == 3) ? 32'hDEAD_BEEF : 32'h0});
    tick();
    @(negedge clk); idle();
    for (int n = 0; n < 16; n++) begin
      e = sb.pop_front(); checks++;
      if (rq[n] !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rq[n], e.val); end
    end
  endtask

  task automatic test_strobes();
    logic [3:0]  g [4];
    logic [15:0] ex [4];
    loadIr(32'h0397_8000);
    g[0] = 4'b0101; ex[0] = 16'h0004;
    g[1] = 4'b0011; ex[1] = 16'h8000;
    g[2] = 4'b1000; ex[2] = 16'h0000;
    g[3] = 4'b1001; ex[3] = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      {Gra, Grb, Grc, Rout} = g[i];
      sb.push_back('{$sformatf("strobe_%0d", i), {16'd0, ex[i]}});
      #1;
      e = sb.pop_front(); checks++;
      if ({16'd0, rOut} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rOut, e.val); end
    end
    @(negedge clk); idle();
  endtask

  task automatic test_baout();
    loadIr(32'h0);
    @(negedge clk); idle(); Grb = 1; Rin = 1; busMuxOut = 32'h55;
    tick();
    @(negedge clk); idle(); Grb = 1; BAout = 1;
    sb.push_back('{"ba_rOut", 32'h1});
    sb.push_back('{"ba_r0Q", 32'h0});
    #1;
    e = sb.pop_front(); checks++;
    if ({16'd0, rOut} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rOut, e.val); end
    e = sb.pop_front(); checks++;
    if (r0Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r0Q, e.val); end
    BAout = 0; Rout = 1;
    sb.push_back('{"rout_r0Q", 32'h55});
    #1;
    e = sb.pop_front(); checks++;
    if (r0Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r0Q, e.val); end
    BAout = 1;
    sb.push_back('{"both_r0Q", 32'h0});
    #1;
    e = sb.pop_front(); checks++;
    if (r0Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r0Q, e.val); end
    @(negedge clk); idle();
  endtask

  task automatic test_sign_extend();
    loadIr(32'h0004_0000);
    sb.push_back('{"sext_neg", 32'hFFFC_0000});
    e = sb.pop_front(); checks++;
    if (C_sign_extended !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, C_sign_extended, e.val); end
    loadIr(32'h0003_FFFF);
    sb.push_back('{"sext_pos", 32'h0003_FFFF});
    e = sb.pop_front(); checks++;
    if (C_sign_extended !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, C_sign_extended, e.val); end
  endtask

  task automatic test_same_cycle();
    // IR holds 0x0003FFFF, rc = 7; the write must use that old rc
    @(negedge clk); idle(); Grc = 1; Rin = 1; IRin = 1; busMuxOut = 32'h0000_8000;
    sb.push_back('{"old_sel_r7", 32'h0000_8000});
    sb.push_back('{"old_sel_r1", 32'h0});
    sb.push_back('{"new_ir", 32'h0000_8000});
    tick();
    e = sb.pop_front(); checks++;
    if (r7Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r7Q, e.val); end
    e = sb.pop_front(); checks++;
    if (r1Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r1Q, e.val); end
    e = sb.pop_front(); checks++;
    if (irQ !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, irQ, e.val); end
    @(negedge clk); idle(); Grc = 1; Rin = 1; busMuxOut = 32'h77;
    tick();
    // Read and write the same register: no bypass
    @(negedge clk); idle(); Grc = 1; Rin = 1; Rout = 1; busMuxOut = 32'h99;
    sb.push_back('{"rw_old", 32'h77});
    sb.push_back('{"rw_rOut", 32'h0002});
    sb.push_back('{"rw_new", 32'h99});
    #1;
    e = sb.pop_front(); checks++;
    if (r1Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r1Q, e.val); end
    e = sb.pop_front(); checks++;
    if ({16'd0, rOut} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rOut, e.val); end
    tick();
    e = sb.pop_front(); checks++;
    if (r1Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r1Q, e.val); end
  endtask

  task automatic test_boundary();
    loadIr(32'h0780_0000);
    @(negedge clk); idle(); Gra = 1; Rin = 1; Rout = 1; busMuxOut = 32'hF00D;
    sb.push_back('{"sel15_rOut", 32'h8000});
    sb.push_back('{"sel15_r15", 32'hF00D});
    #1;
    e = sb.pop_front(); checks++;
    if ({16'd0, rOut} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rOut, e.val); end
    tick();
    e = sb.pop_front(); checks++;
    if (r15Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r15Q, e.val); end
  endtask

  task automatic test_priority_error();
    loadIr(32'h00C8_0000);
    @(negedge clk); idle(); Gra = 1; Grb = 1; Rin = 1; busMuxOut = 32'hA5;
    sb.push_back('{"pri_r1", 32'hA5});
    sb.push_back('{"pri_r9", 32'h0});
    sb.push_back('{"pri_selErr", 32'h1});
    tick();
    e = sb.pop_front(); checks++;
    if (r1Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r1Q, e.val); end
    e = sb.pop_front(); checks++;
    if (r9Q !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, r9Q, e.val); end
    e = sb.pop_front(); checks++;
    if ({31'd0, selErr} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, selErr, e.val); end
    @(negedge clk); idle(); Grc = 1; Rout = 1;
    tick(); tick();
    sb.push_back('{"sticky_selErr", 32'h1});
    e = sb.pop_front(); checks++;
    if ({31'd0, selErr} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, selErr, e.val); end
    @(negedge clk); idle(); clr_n = 0;
    sb.push_back('{"cleared_selErr", 32'h0});
    #1;
    e = sb.pop_front(); checks++;
    if ({31'd0, selErr} !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, selErr, e.val); end
    #1 clr_n = 1;
  endtask

  task automatic test_back_to_back();
    // Every cycle loads a new IR while writing the register picked by the old one
    logic [31:0] m [16];
    logic [31:0] irm;
    logic [31:0] v;
    int          g;
    logic [3:0]  s;
    for (int n = 0; n < 16; n++) m[n] = 32'h0;
    irm = 32'h0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk); idle();
      v = $urandom;
      g = $urandom_range(0, 2);
      if (g == 0) begin Gra = 1; s = irm[26:23]; end
      else if (g == 1) begin Grb = 1; s = irm[22:19]; end
      else begin Grc = 1; s = irm[18:15]; end
      Rin = 1; IRin = 1; busMuxOut = v;
      m[s] = v;
      irm = v;
    end
    tick();
    @(negedge clk); idle();
    for (int n = 0; n < 16; n++) sb.push_back('{$sformatf("b2b_r%0d", n), m[n]});
    sb.push_back('{"b2b_irQ", irm});
    #1;
    for (int n = 0; n < 16; n++) begin
      e = sb.pop_front(); checks++;
      if (rq[n] !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, rq[n], e.val); end
    end
    e = sb.pop_front(); checks++;
    if (irQ !== e.val) begin errors++; $display("[TB] FAIL %s got %h expected %h", e.tag, irQ, e.val); end
  endtask

  initial begin
    test_reset();
    test_ir_write_ra();
    test_strobes();
    test_baout();
    test_sign_extend();
    test_same_cycle();
    test_boundary();
    test_priority_error();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/select_encode_regfile.md
# select_encode_regfile

Destination end of the datapath bus: holds the instruction register and general registers R0–R15, captures `busMuxOut` into the register named by the IR's ra/rb/rc field, and generates the one-hot `R0Out`–`R15Out` source strobes plus register contents that the bus multiplexer selects from. It also produces the sign-extended constant C from the IR. It sits between the control unit, which supplies the Gra/Grb/Grc/Rin/Rout/BAout/IRin strobes, and the bus mux.

## Interface
Parameters:
- none (data width fixed at 32, 16 general registers)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `clr_n`  in  1  asynchronous, active-low reset
- `busMuxOut`  in  32  bus value to capture
- `IRin`  in  1  load IR from `busMuxOut`
- `Gra`, `Grb`, `Grc`  in  1 each  select field ra = IR[26:23], rb = IR[22:19], rc = IR[18:15]
- `Rin`  in  1  write `busMuxOut` into the selected register
- `Rout`  in  1  drive the source strobe of the selected register
- `BAout`  in  1  as `Rout`, but R0 reads as 0 (base-address semantics)
- `irQ`  out  32  IR contents
- `r0Q` … `r15Q`  out  32 each  register contents presented to the bus mux (`r0Q` gated by BAout)
- `rOut`  out  16  one-hot source strobes, bit n → bus mux `RnOut`
- `C_sign_extended`  out  32  {{13{IR[18]}}, IR[18:0]}
- `selErr`  out  1  sticky ambiguous-select flag

## Operation
- Field select: sel = IR[26:23] if Gra, else IR[22:19] if Grb, else IR[18:15] if Grc. Priority is Gra > Grb > Grc. With none asserted there is no selection: `rOut` = 0 and no write occurs.
- Decode: a 4-to-16 one-hot decode of sel, qualified by (Gra|Grb|Grc).
- Write: on rising `clk`, if `Rin` and a select is active, Rsel ← `busMuxOut`. All other registers hold. R0 is writable.
- Read strobes: `rOut[n]` = decode[n] & (`Rout` | `BAout`). The output is combinational.
- `r0Q` = `BAout` ? 0 : R0. `rNq` = Rn for n ≥ 1. Outputs are combinational from the registers.
- IR: on rising `clk`, if `IRin`, IR ← `busMuxOut`.
- `selErr`: set on a rising edge when more than one of Gra/Grb/Grc is high while (`Rin`|`Rout`|`BAout`). It is cleared only by reset.

## Timing
- Reset (`clr_n` low, asynchronous): IR, R0–R15 and `selErr` all become 0. Consequently `irQ` = 0, all `rNq` = 0, `C_sign_extended` = 0, and `rOut` follows the inputs with sel = 0.
- Reset deassertion mid-sequence: no state is retained and the first edge after release behaves normally.
- Write latency: the value is visible on `rNq` after the capturing edge (1 cycle). Read strobes and data have zero-cycle combinational latency.
- Same-cycle `Rin` + `IRin`: the register write uses sel from the old IR. The new IR affects selection from the next cycle on.
- Same-cycle read and write of one register (`Rout` + `Rin`, same sel): the bus sees the old contents and the register takes `busMuxOut` at the edge. There is no bypass.
- `Rout` and `BAout` together: treated as `BAout`, so `r0Q` is 0 when sel = 0.
- IR field boundary: sel = 15 selects R15. All 16 decode outputs are reachable, with no wrap.

## Test plan
- Reset: after writing R5 = 0x1234_5678, pulse `clr_n` low with no clock edge. Expect `r5Q` = 0, `irQ` = 0 and `selErr` = 0 immediately.
- IR load and write, ra: with `IRin` and `busMuxOut` = 0x0180_0000 (ra = 3), `irQ` = 0x0180_0000 next cycle. Then Gra+Rin with bus = 0xDEAD_BEEF gives `r3Q` = 0xDEAD_BEEF, and all other registers stay 0.
- Strobes: with IR ra = 7, rb = 2, rc = 15, assert Grb+Rout, then Grc+Rout, then Gra only. Expect `rOut` = 0x0004, then 0x8000, then 0x0000.
- BAout: with R0 = 0x55, IR rb = 0, Grb+BAout gives `rOut` = 0x0001 and `r0Q` = 0. With Grb+Rout, `r0Q` = 0x55.
- Sign extend: IR = 0x0004_0000 (IR[18] = 1) gives `C_sign_extended` = 0xFFFC_0000. IR = 0x0003_FFFF gives 0x0003_FFFF.
- Priority and error: with ra = 1 and rb = 9, Gra+Grb+Rin and bus = 0xA5 writes only R1 and sets `selErr` = 1. `selErr` stays 1 until `clr_n` goes low.
